// File: rtl/gap_regex_engine.sv
// gap_regex_engine: streaming matcher for  ^PREFIX [gap-class]* SUFFIX
// over a byte stream. An external decoder supplies per-byte class hits;
// this block runs one-hot prefix/suffix chains joined by a gap tracker.
//
// Ports:
//   clk          - clock
//   sod          - start-of-data, async active-high reset of all state
//   en           - a byte is presented this cycle
//   hit_p        - bit i: byte matches prefix class i
//   hit_s        - bit j: byte matches suffix class j
//   gap_ok       - byte belongs to the gap class (not CR, not LF)
//   nl           - byte is LF
//   match        - sticky: at least one match since sod
//   match_pulse  - one cycle per completed suffix
//   match_cnt    - saturating count of completed suffixes
//   first_pos    - byte index (0-based, saturating) of the first match's last byte
module gap_regex_engine #(
  parameter int unsigned P_LEN     = 12,
  parameter int unsigned S_LEN     = 8,
  parameter int unsigned GAP_MAX   = 0,
  parameter int unsigned ANCHORED  = 1,
  parameter int unsigned MULTILINE = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             sod,
  input  logic             en,
  input  logic [P_LEN-1:0] hit_p,
  input  logic [S_LEN-1:0] hit_s,
  input  logic             gap_ok,
  input  logic             nl,
  output logic             match,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] first_pos
);

  // Suffix chain keeps only the first S_LEN-1 stages; the last stage is the
  // combinational final-byte condition.
  localparam int unsigned SW = (S_LEN > 1) ? S_LEN - 1 : 1;
  localparam int unsigned GW = $clog2(GAP_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             start_pend_q, start_pend_d;
  logic [P_LEN-1:0] p_q, p_d;
  logic             g_q, g_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [SW-1:0]    s_q, s_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             match_q, match_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] fpos_q, fpos_d;

  logic start, pdone, gap_open, gap_room, seed, done_n, hit_now;

  // Line-start token, gap window and final-byte detection
  always_comb begin
    start    = start_pend_q | (ANCHORED == 0);
    pdone    = p_q[P_LEN-1];
    gap_open = pdone | g_q;
    // A fresh prefix restarts the gap count, so it always has room for one byte.
    gap_room = (GAP_MAX == 0) | pdone | (gcnt_q < GW'(GAP_MAX));
    seed     = hit_s[0] & gap_open;
    if (S_LEN == 1) begin
      done_n = seed;
    end else begin
      done_n = s_q[SW-1] & hit_s[S_LEN-1];
    end
    hit_now = en & done_n;
  end

  // Next-state for chains, gap tracker and counters
  always_comb begin
    start_pend_d = start_pend_q;
    p_d          = p_q;
    g_d          = g_q;
    gcnt_d       = gcnt_q;
    s_d          = s_q;
    bcnt_d       = bcnt_q;
    match_d      = match_q | hit_now;
    pulse_d      = hit_now;
    mcnt_d       = mcnt_q;
    fpos_d       = fpos_q;
    if (en) begin
      start_pend_d = (MULTILINE != 0) & nl;
      p_d[0] = start & hit_p[0];
      for (int i = 1; i < int'(P_LEN); i++) begin
        p_d[i] = p_q[i-1] & hit_p[i];
      end
      g_d = gap_ok & gap_open & gap_room;
      if (pdone & gap_ok) begin
        gcnt_d = GW'(1);
      end else if (g_q & gap_ok) begin
        gcnt_d = gcnt_q + GW'(1);
      end else begin
        gcnt_d = '0;
      end
      if (S_LEN == 1) begin
        s_d = '0;
      end else begin
        s_d[0] = seed;
        for (int j = 1; j < int'(SW); j++) begin
          s_d[j] = s_q[j-1] & hit_s[j];
        end
      end
      if (bcnt_q != CNT_MAX) begin
        bcnt_d = bcnt_q + CNT_W'(1);
      end
      if (done_n) begin
        if (mcnt_q != CNT_MAX) begin
          mcnt_d = mcnt_q + CNT_W'(1);
        end
        if (!match_q) begin
          fpos_d = bcnt_q;
        end
      end
    end
  end

  // State registers; sod clears everything and arms the line-start token
  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      start_pend_q <= 1'b1;
      p_q          <= '0;
      g_q          <= 1'b0;
      gcnt_q       <= '0;
      s_q          <= '0;
      bcnt_q       <= '0;
      match_q      <= 1'b0;
      pulse_q      <= 1'b0;
      mcnt_q       <= '0;
      fpos_q       <= '0;
    end else begin
      start_pend_q <= start_pend_d;
      p_q          <= p_d;
      g_q          <= g_d;
      gcnt_q       <= gcnt_d;
      s_q          <= s_d;
      bcnt_q       <= bcnt_d;
      match_q      <= match_d;
      pulse_q      <= pulse_d;
      mcnt_q       <= mcnt_d;
      fpos_q       <= fpos_d;
    end
  end

  assign match       = match_q;
  assign match_pulse = pulse_q;
  assign match_cnt   = mcnt_q;
  assign first_pos   = fpos_q;

endmodule

// File: doc/gap_regex_engine.md
GAP_REGEX_ENGINE -- requirements
Module: gap_regex_engine

Interface
REQ-001 The block SHALL have parameter P_LEN, default 12: prefix literal length in byte positions, 1..32.
REQ-002 The block SHALL have parameter S_LEN, default 8: suffix literal length in byte positions, 1..32.
REQ-003 The block SHALL have parameter GAP_MAX, default 0: maximum gap bytes between prefix and suffix; 0 = unbounded.
REQ-004 The block SHALL have parameter ANCHORED, default 1: 1 = prefix must start at a line/data start; 0 = prefix may start at any byte.
REQ-005 The block SHALL have parameter MULTILINE, default 1: 1 = the byte after a newline byte is also a line start.
REQ-006 The block SHALL have parameter CNT_W, default 16: width of the byte counter and match counter.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port sod, input, 1 bit: start-of-data; asynchronous, active-high reset of all state.
REQ-009 The block SHALL have port en, input, 1 bit: a byte is presented this cycle.
REQ-010 The block SHALL have port hit_p, input, P_LEN bits: bit i = byte matches prefix class i (from the external decoder).
REQ-011 The block SHALL have port hit_s, input, S_LEN bits: bit j = byte matches suffix class j.
REQ-012 The block SHALL have port gap_ok, input, 1 bit: byte is in the gap class (not CR, not LF).
REQ-013 The block SHALL have port nl, input, 1 bit: byte is LF.
REQ-014 The block SHALL have port match, output, 1 bit: sticky match flag.
REQ-015 The block SHALL have port match_pulse, output, 1 bit: one-cycle pulse per completed suffix.
REQ-016 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of completed suffixes.
REQ-017 The block SHALL have port first_pos, output, CNT_W bits: byte index (0-based, saturating) of the final byte of the first match.

Function
REQ-018 All state SHALL update only on rising clk edges with en=1; when en=0, all state SHALL hold and match_pulse SHALL be 0.
REQ-019 The start token SHALL be 1 for the first en byte after sod; for the byte after an en byte with nl=1 when MULTILINE=1; and for every byte when ANCHORED=0.
REQ-020 The prefix SHALL be a one-hot shift chain: p[0] <= start & hit_p[0]; p[i] <= p[i-1] & hit_p[i]; pdone = p[P_LEN-1].
REQ-021 Gap state SHALL be g <= gap_ok & (pdone | g) & (GAP_MAX==0 | gcnt < GAP_MAX).
REQ-022 gcnt SHALL load 1 when pdone & gap_ok, increment while g & gap_ok, and clear otherwise.
REQ-023 A new pdone SHALL always restart gcnt, so the most recent prefix governs the bound.
REQ-024 The suffix SHALL be a chain: s[0] <= hit_s[0] & (pdone | g); s[j] <= s[j-1] & hit_s[j].
REQ-025 A zero-length gap SHALL be legal.
REQ-026 The final-byte condition SHALL be done_n = s[S_LEN-2] & hit_s[S_LEN-1] (or hit_s[0] & (pdone|g) when S_LEN=1).
REQ-027 On the edge consuming the final suffix byte, match SHALL set, match_pulse SHALL be 1 for that cycle, and match_cnt SHALL increment, saturating at all-ones.
REQ-028 first_pos SHALL capture the byte counter value only on the first match.
REQ-029 The byte counter SHALL increment per en byte and saturate at all-ones.
REQ-030 Overlapping prefix/suffix attempts SHALL be tracked concurrently by the one-hot chains without loss.
REQ-031 Matches SHALL be counted on every edge where done_n is true.
REQ-032 match SHALL remain 1 until sod.

Reset
REQ-033 While sod=1, all chains, gcnt, and the byte counter SHALL be 0, and all outputs SHALL be 0.
REQ-034 Start-pending SHALL be set while sod=1 so that the first byte after release is a line start.
REQ-035 sod SHALL dominate en in the same cycle.
REQ-036 sod asserted mid-match SHALL abort the match with no pulse.

Verification (decoder model: prefix "UA:", suffix "NL2", P_LEN=3, S_LEN=3)
REQ-037 Bytes "UA:xyzNL2" after sod -> match_pulse at byte 8; match=1, match_cnt=1, first_pos=8.
REQ-038 Bytes "xUA:NL2" with ANCHORED=1 -> no match; with ANCHORED=0 -> match with first_pos=6.
REQ-039 Bytes "q\nUA:NL2": MULTILINE=1 -> match at first_pos=7; MULTILINE=0 -> no match.
REQ-040 Bytes "UA:ab\rNL2" -> no match, because CR kills the gap.
REQ-041 GAP_MAX=2: "UA:abNL2" -> match; "UA:abcNL2" -> no match.
REQ-042 en toggled 0/1 every cycle through REQ-037 -> identical result at byte 8.
REQ-043 sod pulsed between "N" and "L" -> outputs return to 0 and no pulse occurs.
REQ-044 Two back-to-back matches on separate lines -> match_cnt=2, and first_pos holds the first match's position.
